// File: rtl/mux_arb_pkg.sv
// Shared constants and FSM state type for the 4-way round-robin mux arbiter.
`timescale 1ns/1ps
package mux_arb_pkg;
  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_e;
endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first set request bit at or after ptr, wrapping mod 4.
`timescale 1ns/1ps
module rr_pick4
  import mux_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               found,
  output logic [SEL_W-1:0]   idx
);

  logic [SEL_W-1:0] cand;

  // Scan from farthest to nearest offset so the nearest requester is the last write.
  always_comb begin
    found = 1'b0;
    idx   = ptr;
    cand  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ptr + k[SEL_W-1:0];
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter4.sv
// Round-robin arbiter driving a registered 4:1 mux; MUX_ARB_TIMEOUT_EN adds a MAX_HOLD grant limit.
// Handshake: a source owns the mux while req[i] stays high; each grant ends with a one-cycle GAP.
`timescale 1ns/1ps
module mux_rr_arbiter4
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] din,
  output logic [NUM_REQ-1:0] gnt,
  output logic [SEL_W-1:0]   sel,
  output logic               en,
  output logic               y,
  output logic               busy
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("MAX_HOLD must be in 2..255");
  end

  arb_state_e         state_q, state_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               en_q, en_d;
  logic               y_q, y_d;
  logic               pick_found;
  logic [SEL_W-1:0]   pick_idx;
  logic               grant_end;

`ifdef MUX_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] hold_q, hold_d;
`endif

  rr_pick4 u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    en_d      = en_q;
    y_d       = en_q ? din[sel_q] : 1'b0;
    grant_end = 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
    hold_d    = hold_q;
`endif
    case (state_q)
      GRANT: begin
`ifdef MUX_ARB_TIMEOUT_EN
        // hold_q counts GRANT cycles already completed before this one.
        grant_end = !req[sel_q] || (hold_q == HOLD_LAST);
        hold_d    = hold_q + 8'd1;
`else
        grant_end = !req[sel_q];
`endif
        if (grant_end) begin
          state_d = GAP;
          gnt_d   = '0;
          en_d    = 1'b0;
          ptr_d   = sel_q + 2'd1;
        end
      end
      default: begin
        // IDLE and GAP arbitrate identically; sel keeps its last value when nobody wins.
        if (pick_found) begin
          state_d         = GRANT;
          gnt_d           = '0;
          gnt_d[pick_idx] = 1'b1;
          sel_d           = pick_idx;
          en_d            = 1'b1;
`ifdef MUX_ARB_TIMEOUT_EN
          hold_d          = 8'd0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      sel_q   <= '0;
      en_q    <= 1'b0;
      y_q     <= 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
      hold_q  <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      y_q     <= y_d;
`ifdef MUX_ARB_TIMEOUT_EN
      hold_q  <= hold_d;
`endif
    end
  end

  assign gnt  = gnt_q;
  assign sel  = sel_q;
  assign en   = en_q;
  assign y    = y_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_mux_rr_arbiter4.sv
// Bench for mux_rr_arbiter4: directed scenarios plus random traffic against a behavioural model.
`timescale 1ns/1ps
module tb_mux_rr_arbiter4;

  localparam int MAX_HOLD = 8;
`ifdef MUX_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] din;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       en;
  logic       y;
  logic       busy;

  mux_rr_arbiter4 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .din   (din),
    .gnt   (gnt),
    .sel   (sel),
    .en    (en),
    .y     (y),
    .busy  (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog");
  end

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // behavioural model: who holds the mux, for how long, and where the next search starts
  int   m_cur;
  int   m_sel;
  int   m_ptr;
  int   m_held;
  bit   m_gap;
  logic m_y;

  function automatic int rr_first(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_cur = -1; m_sel = 0; m_ptr = 0; m_held = 0; m_gap = 1'b0; m_y = 1'b0;
  endtask

  function automatic logic [8:0] model_pack();
    logic [3:0] g;
    g = 4'b0000;
    if (m_cur >= 0) g[m_cur] = 1'b1;
    return {g, 2'(m_sel), (m_cur >= 0), m_y, ((m_cur >= 0) || m_gap)};
  endfunction

  task automatic model_step(input logic [3:0] r, input logic [3:0] d);
    logic ny;
    int   w;
    ny = (m_cur >= 0) ? d[m_cur] : 1'b0;
    if (m_cur >= 0) begin
      m_held++;
      if (!r[m_cur] || (TO_EN && m_held >= MAX_HOLD)) begin
        m_ptr = (m_cur + 1) % 4;
        m_cur = -1;
        m_gap = 1'b1;
      end
    end else begin
      m_gap = 1'b0;
      w = rr_first(r, m_ptr);
      if (w >= 0) begin
        m_cur  = w;
        m_sel  = w;
        m_held = 0;
      end
    end
    m_y = ny;
  endtask

  // driver tasks
  task automatic step(input logic [3:0] r, input logic [3:0] d);
    @(negedge clk);
    if (exp_q.size() > 0) check_val("cycle", {7'd0, gnt, sel, en, y, busy}, {7'd0, exp_q.pop_front()});
    req = r;
    din = d;
    model_step(r, d);
    exp_q.push_back(model_pack());
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    din   = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_gnt", {12'd0, gnt}, 16'd0);
    check_val("rst_sel", {14'd0, sel}, 16'd0);
    check_val("rst_en_y_busy", {13'd0, en, y, busy}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    exp_q.delete();
    exp_q.push_back(model_pack());
  endtask

  task automatic async_reset_mid();
    @(negedge clk);
    if (exp_q.size() > 0) check_val("cycle", {7'd0, gnt, sel, en, y, busy}, {7'd0, exp_q.pop_front()});
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_gnt", {12'd0, gnt}, 16'd0);
    check_val("arst_en_y_busy", {13'd0, en, y, busy}, 16'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    req   = 4'b0000;
    din   = 4'b0000;
    rst_n = 1'b1;
    model_reset();
    exp_q.delete();
    exp_q.push_back(model_pack());
  endtask

  // stimulus
  logic [3:0] r_rand;

  initial begin
    do_reset();

    for (int i = 0; i < 10; i++) step(4'b0000, 4'($urandom_range(0, 15)));

    // two requesters, ptr at 0: source 1 first, then source 3 after a gap
    step(4'b1010, 4'b0000);
    after_edge();
    check_val("r028_gnt1", {12'd0, gnt}, 16'h0002);
    check_val("r028_sel1", {14'd0, sel}, 16'h0001);
    step(4'b1010, 4'b0000);
    step(4'b1000, 4'b0000);
    after_edge();
    check_val("r028_gap", {10'd0, gnt, en, busy}, 16'h0001);
    step(4'b1000, 4'b0000);
    after_edge();
    check_val("r028_gnt3", {10'd0, gnt, sel}, {10'd0, 4'b1000, 2'b11});
    step(4'b0000, 4'b0000);
    step(4'b0000, 4'b0000);
    step(4'b1111, 4'b0000);
    after_edge();
    check_val("r028_ptr_wrap", {12'd0, gnt}, 16'h0001);

    for (int i = 0; i < 45; i++) step(4'b1111, 4'($urandom_range(0, 15)));
    after_edge();
`ifdef MUX_ARB_TIMEOUT_EN
    check_val("r029_rotated", {14'd0, busy, en}, {14'd0, 2'(m_cur >= 0 || m_gap), 1'(m_cur >= 0)});
`else
    check_val("r030_held0", {12'd0, gnt}, 16'h0001);
`endif
    step(4'b0000, 4'b0000);
    step(4'b0000, 4'b0000);
    step(4'b0000, 4'b0000);

    // data path through source 2
    step(4'b0100, 4'b0000);
    step(4'b0100, 4'b0100);
    after_edge();
    check_val("r031_y1", {15'd0, y}, 16'd1);
    step(4'b0100, 4'b0000);
    after_edge();
    check_val("r031_y0", {15'd0, y}, 16'd0);
    step(4'b0100, 4'b0100);
    step(4'b0000, 4'b0100);
    step(4'b0000, 4'b0100);
    after_edge();
    check_val("r031_y_after_en", {15'd0, y}, 16'd0);
    step(4'b0000, 4'b0000);

    // async reset while source 3 drives y high
    step(4'b1000, 4'b1000);
    step(4'b1000, 4'b1000);
    step(4'b1000, 4'b1000);
    async_reset_mid();
    step(4'b1001, 4'b0000);
    after_edge();
    check_val("r032_first", {12'd0, gnt}, 16'h0001);
    step(4'b0000, 4'b0000);
    step(4'b0000, 4'b0000);

    // random traffic with sticky requests
    r_rand = 4'b0000;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) r_rand = 4'($urandom_range(0, 15));
      if (i == 700) async_reset_mid();
      step(r_rand, 4'($urandom_range(0, 15)));
    end

    @(negedge clk);
    if (exp_q.size() > 0) check_val("cycle", {7'd0, gnt, sel, en, y, busy}, {7'd0, exp_q.pop_front()});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_rr_arbiter4.md
MUX_RR_ARBITER4 -- requirements
Module: mux_rr_arbiter4

Interface
REQ-001 Parameter MAX_HOLD, default 8: maximum consecutive GRANT cycles per grant (range 2..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req  input  4  request per source; bit i requests use of data line i.
REQ-005 din  input  4  data lines I0..I3; din[i] = Ii.
REQ-006 gnt  output  4  one-hot grant, registered; all-zero when no grant.
REQ-007 sel  output  2  mux select {s1,s0} = index of granted source, registered.
REQ-008 en  output  1  mux enable, registered; 1 only in GRANT.
REQ-009 y  output  1  registered mux output: din[sel] when en, else 0.
REQ-010 busy  output  1  1 whenever state is not IDLE.

Function
REQ-011 FSM states SHALL be exactly IDLE, GRANT, GAP.
REQ-012 IDLE: if req != 0, go to GRANT next edge with winner = first set bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4); else stay IDLE.
REQ-013 Latency: req seen at edge N in IDLE -> gnt/sel/en valid after edge N+1 is not permitted; they SHALL be valid after edge N (one registered stage).
REQ-014 GRANT: gnt one-hot of winner, sel = winner, en = 1; grant held while req[winner] = 1.
REQ-015 GRANT -> GAP when req[winner] = 0 or, with timeout compiled in, hold count reaches MAX_HOLD.
REQ-016 GAP lasts exactly one cycle with gnt = 0, en = 0, sel holding last value (break-before-make); then IDLE rules of REQ-012 apply from GAP directly, so GAP -> GRANT if any req set, else GAP -> IDLE.
REQ-017 ptr SHALL update to (winner + 1) mod 4 on every GRANT -> GAP transition; ptr wraps 3 -> 0.
REQ-018 Requests changing on non-granted bits during GRANT SHALL not affect gnt, sel or en.
REQ-019 y SHALL be registered from din[sel] gated by en, i.e. y lags sel/en by one cycle; y = 0 the cycle after en = 0.
REQ-020 gnt SHALL never have more than one bit set; en = 1 iff gnt != 0.

Reset
REQ-021 While rst_n = 0: state IDLE, ptr = 0, hold count = 0, gnt = 0, sel = 0, en = 0, y = 0, busy = 0.
REQ-022 Reset asserted mid-GRANT SHALL drop en and gnt immediately (asynchronous), with no GAP cycle; after release arbitration restarts with ptr = 0.

Configuration
REQ-023 Macro MUX_ARB_TIMEOUT_EN defined: 8-bit hold counter clears on entry to GRANT, increments each GRANT cycle; at MAX_HOLD GRANT is forced to GAP even if req[winner] = 1.
REQ-024 MUX_ARB_TIMEOUT_EN undefined: no counter, MAX_HOLD ignored, grant held indefinitely while req[winner] = 1.

Structure
REQ-025 Package mux_arb_pkg SHALL hold NUM_REQ = 4, SEL_W = 2 and the state enum (IDLE, GRANT, GAP).
REQ-026 Combinational round-robin picker SHALL be sub-module rr_pick4 (inputs req, ptr; outputs found, idx); FSM, counter and output registers stay in mux_rr_arbiter4.

Verification
REQ-027 Reset then req = 4'b0000 for 10 cycles -> gnt = 0, en = 0, busy = 0, y = 0 throughout.
REQ-028 req = 4'b1010 held, ptr = 0 -> gnt = 4'b0010, sel = 2'b01; drop req[1] -> one GAP cycle, then gnt = 4'b1000, sel = 2'b11, ptr becomes 0 after that grant ends.
REQ-029 req = 4'b1111 held, timeout compiled in, MAX_HOLD = 8 -> grants rotate 0,1,2,3,0, each 8 cycles en = 1 plus one GAP cycle.
REQ-030 Same stimulus without MUX_ARB_TIMEOUT_EN -> gnt = 4'b0001 for the whole run.
REQ-031 Grant to source 2, din = 4'b0100 then 4'b0000 -> y = 1 then 0, each one cycle after din change; y = 0 one cycle after en falls.
REQ-032 rst_n pulled low mid-GRANT to source 3 -> gnt, en, y = 0 without waiting for clk; after release with req = 4'b1001 first grant goes to source 0.
